gcd_lcm_seq: RTL

Sequential, handshaked GCD/LCM engine that consumes operand pairs from an upstream producer and returns results to a downstream consumer. It computes the greatest common divisor by iterative subtraction, one step per cycle, and derives the LCM by shift-subtract division and shift-add multiplication. It is the multicycle, flow-controlled counterpart to the team's combinational GCD datapath, for use where operands arrive as a stream and area matters more than latency.

---
 rtl/gcd_lcm_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/gcd_lcm_seq.sv
// Handshaked GCD/LCM engine: GCD by repeated subtraction, then LCM = (a/gcd) * b
// using a restoring divider and a shift-add multiplier that share the quotient register.
module gcd_lcm_seq #(
    parameter int W = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   gcd,
    output logic [2*W-1:0] lcm,
    output logic           err
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [2:0] {S_IDLE, S_GCD, S_DIV, S_MUL, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     x_q, x_d, y_q, y_d;
    logic [W-1:0]     ar_q, ar_d, br_q, br_d;
    logic [W-1:0]     gcd_q, gcd_d;
    logic [2*W-1:0]   lcm_q, lcm_d;
    logic             err_q, err_d;
    logic [W:0]       rem_q, rem_d;
    logic [W-1:0]     quo_q, quo_d;
    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W:0]       rem_shift;
    logic [2*W-1:0]   acc_sum;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        ar_d      = ar_q;
        br_d      = br_q;
        gcd_d     = gcd_q;
        lcm_d     = lcm_q;
        err_d     = err_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        rem_shift = {rem_q[W-1:0], quo_q[W-1]};
        acc_sum   = quo_q[0] ? (acc_q + mcand_q) : acc_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d   = a;
                    y_d   = b;
                    ar_d  = a;
                    br_d  = b;
                    err_d = 1'b0;
                    gcd_d = '0;
                    lcm_d = '0;
                    if (a == '0 && b == '0) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (a == '0 || b == '0) begin
                        gcd_d   = a | b;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GCD;
                    end
                end
            end
            S_GCD: begin
                if (x_q > y_q) begin
                    x_d = x_q - y_q;
                end else if (y_q > x_q) begin
                    y_d = y_q - x_q;
                end else begin
                    gcd_d   = x_q;
                    rem_d   = '0;
                    quo_d   = ar_q;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                // Dividend bits shift out of quo_q as quotient bits shift in.
                quo_d = {quo_q[W-2:0], 1'b0};
                rem_d = rem_shift;
                if (rem_shift >= {1'b0, gcd_q}) begin
                    rem_d    = rem_shift - {1'b0, gcd_q};
                    quo_d[0] = 1'b1;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    mcand_d = {{W{1'b0}}, br_q};
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                acc_d   = acc_sum;
                mcand_d = mcand_q << 1;
                quo_d   = quo_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    cnt_d   = '0;
                    lcm_d   = acc_sum;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            ar_q    <= '0;
            br_q    <= '0;
            gcd_q   <= '0;
            lcm_q   <= '0;
            err_q   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ar_q    <= ar_d;
            br_q    <= br_d;
            gcd_q   <= gcd_d;
            lcm_q   <= lcm_d;
            err_q   <= err_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign gcd       = gcd_q;
    assign lcm       = lcm_q;
    assign err       = err_q;

endmodule
